// File: rtl/fir_channel_arbiter_if.sv
// Producer/filter-side bundle of the two-channel FIR arbiter.
// The arbiter uses the slave view; the producers and filter use the master view.
interface fir_channel_arbiter_if;
  logic [1:0]  req_valid;
  logic [15:0] req_sample0;
  logic [15:0] req_sample1;
  logic [1:0]  req_ack;
  logic        coeff_busy;
  logic        modwait;
  logic [15:0] fir_out;
  logic        err;
  logic [15:0] sample_data;
  logic        data_ready;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        active_ch;

  modport slave (
    input  req_valid, req_sample0, req_sample1, coeff_busy, modwait, fir_out, err,
    output req_ack, sample_data, data_ready, rsp_valid, rsp_data, rsp_err, active_ch
  );

  modport master (
    output req_valid, req_sample0, req_sample1, coeff_busy, modwait, fir_out, err,
    input  req_ack, sample_data, data_ready, rsp_valid, rsp_data, rsp_err, active_ch
  );
endinterface

// File: rtl/fir_channel_arbiter.sv
// Round-robin arbiter that time-shares one FIR datapath between two sample
// producers and routes each result and its error flag back to its channel.
module fir_channel_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  fir_channel_arbiter_if.slave  bus
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic            last_grant, last_grant_nxt;
  logic            err_latch, err_latch_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [DW-1:0]   sample_q, sample_nxt;
  logic            data_ready_q, data_ready_nxt;
  logic [1:0]      req_ack_q, req_ack_nxt;
  logic [1:0]      rsp_valid_q, rsp_valid_nxt;
  logic [DW-1:0]   rsp_data_q, rsp_data_nxt;
  logic            rsp_err_q, rsp_err_nxt;
  logic            active_q, active_nxt;
  logic            grant_ch_c;
  logic [1:0]      active_onehot_c;

  // Tie goes to the channel that did not win last time.
  assign grant_ch_c      = (bus.req_valid == 2'b11) ? ~last_grant : bus.req_valid[1];
  assign active_onehot_c = active_q ? 2'b10 : 2'b01;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    err_latch_nxt  = err_latch;
    cnt_nxt        = cnt;
    sample_nxt     = sample_q;
    data_ready_nxt = data_ready_q;
    req_ack_nxt    = 2'b00;
    rsp_valid_nxt  = 2'b00;
    rsp_data_nxt   = rsp_data_q;
    rsp_err_nxt    = rsp_err_q;
    active_nxt     = active_q;

    case (state)
      IDLE: begin
        if ((|bus.req_valid) && !bus.coeff_busy && !bus.modwait) begin
          state_nxt      = ISSUE;
          active_nxt     = grant_ch_c;
          last_grant_nxt = grant_ch_c;
          sample_nxt     = grant_ch_c ? bus.req_sample1 : bus.req_sample0;
          req_ack_nxt    = grant_ch_c ? 2'b10 : 2'b01;
          data_ready_nxt = 1'b1;
          cnt_nxt        = '0;
        end
      end
      ISSUE: begin
        if (bus.modwait) begin
          state_nxt      = BUSY;
          data_ready_nxt = 1'b0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          // Filter never accepted the sample: return an error with no data.
          state_nxt      = DONE;
          data_ready_nxt = 1'b0;
          rsp_valid_nxt  = active_onehot_c;
          rsp_data_nxt   = '0;
          rsp_err_nxt    = 1'b1;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      BUSY: begin
        err_latch_nxt = err_latch | bus.err;
        if (!bus.modwait) begin
          state_nxt     = DONE;
          rsp_valid_nxt = active_onehot_c;
          rsp_data_nxt  = bus.fir_out;
          rsp_err_nxt   = err_latch | bus.err;
        end
      end
      DONE: begin
        state_nxt     = IDLE;
        err_latch_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      err_latch    <= 1'b0;
      cnt          <= '0;
      sample_q     <= '0;
      data_ready_q <= 1'b0;
      req_ack_q    <= 2'b00;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state        <= state_nxt;
      last_grant   <= last_grant_nxt;
      err_latch    <= err_latch_nxt;
      cnt          <= cnt_nxt;
      sample_q     <= sample_nxt;
      data_ready_q <= data_ready_nxt;
      req_ack_q    <= req_ack_nxt;
      rsp_valid_q  <= rsp_valid_nxt;
      rsp_data_q   <= rsp_data_nxt;
      rsp_err_q    <= rsp_err_nxt;
      active_q     <= active_nxt;
    end
  end

  assign bus.sample_data = sample_q;
  assign bus.data_ready  = data_ready_q;
  assign bus.req_ack     = req_ack_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.active_ch   = active_q;

endmodule

// File: tb/tb_fir_channel_arbiter.sv
// Directed bench for fir_channel_arbiter: the bench plays both producers and
// a cycle-scripted filter, checking handshakes and results against hand values.
module tb_fir_channel_arbiter;

  logic clk;
  logic n_rst;
  int   n_tests;
  int   n_fail;

  fir_channel_arbiter_if bus();

  fir_channel_arbiter #(.TIMEOUT(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    n_rst = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  // One full transaction: wait for the grant, then script the filter.
  task automatic run_txn(input string tag, input logic [1:0] exp_ack, input logic [15:0] exp_smp,
                         input logic [15:0] res, input bit err_mid, input bit never, input int max_wait);
    bit seen;
    int n;
    seen = 1'b0;
    for (int i = 0; i < max_wait && !seen; i++) begin
      tick();
      if (bus.req_ack != 2'b00) seen = 1'b1;
    end
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({tag, "_req_ack"}, 32'(bus.req_ack), 32'(exp_ack));
    check({tag, "_sample"}, 32'(bus.sample_data), 32'(exp_smp));
    check({tag, "_data_ready"}, 32'(bus.data_ready), 32'd1);
    check({tag, "_active_ch"}, 32'(bus.active_ch), 32'(exp_ack[1]));
    if (never) begin
      n = 1;
      while (bus.data_ready && n < 20) begin
        tick();
        if (bus.data_ready) n++;
      end
      check({tag, "_dr_cycles"}, 32'(n), 32'd8);
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(exp_ack));
      check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'h0);
      check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd1);
    end else begin
      tick();
      check({tag, "_ack_pulse"}, 32'(bus.req_ack), 32'h0);
      check({tag, "_dr_hold"}, 32'(bus.data_ready), 32'd1);
      bus.modwait = 1'b1;
      tick();
      check({tag, "_dr_drop"}, 32'(bus.data_ready), 32'd0);
      for (int i = 1; i <= 5; i++) begin
        bus.err = (err_mid && i == 2);
        tick();
      end
      bus.err     = 1'b0;
      bus.modwait = 1'b0;
      bus.fir_out = res;
      check({tag, "_no_early_rsp"}, 32'(bus.rsp_valid), 32'h0);
      tick();
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(exp_ack));
      check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(res));
      check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(err_mid));
    end
    tick();
    check({tag, "_rsp_pulse"}, 32'(bus.rsp_valid), 32'h0);
  endtask

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    n_rst            = 1'b0;
    bus.req_valid    = 2'b00;
    bus.req_sample0  = 16'h0;
    bus.req_sample1  = 16'h0;
    bus.coeff_busy   = 1'b0;
    bus.modwait      = 1'b0;
    bus.fir_out      = 16'h0;
    bus.err          = 1'b0;
    #12;
    check("rst_sample", 32'(bus.sample_data), 32'h0);
    check("rst_dr", 32'(bus.data_ready), 32'h0);
    check("rst_ack", 32'(bus.req_ack), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    check("rst_active", 32'(bus.active_ch), 32'h0);
    tick();
    n_rst = 1'b1;
    tick();

    // Single channel
    bus.req_sample0 = 16'h1234;
    bus.req_valid   = 2'b01;
    run_txn("single", 2'b01, 16'h1234, 16'h0ABC, 1'b0, 1'b0, 20);
    bus.req_valid = 2'b00;
    tick();

    // Contention: alternate ch0, ch1 from a fresh reset
    apply_reset();
    bus.req_sample0 = 16'hAAAA;
    bus.req_sample1 = 16'h5555;
    bus.req_valid   = 2'b11;
    run_txn("rr0", 2'b01, 16'hAAAA, 16'h0101, 1'b0, 1'b0, 20);
    run_txn("rr1", 2'b10, 16'h5555, 16'h0202, 1'b0, 1'b0, 20);
    run_txn("rr2", 2'b01, 16'hAAAA, 16'h0303, 1'b0, 1'b0, 20);
    run_txn("rr3", 2'b10, 16'h5555, 16'h0404, 1'b0, 1'b0, 20);
    bus.req_valid = 2'b00;
    tick();

    // Coefficient reload blocks grants
    bus.req_sample1 = 16'hBEEF;
    bus.req_valid   = 2'b10;
    bus.coeff_busy  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("coeff_no_ack", 32'(bus.req_ack), 32'h0);
      check("coeff_no_dr", 32'(bus.data_ready), 32'h0);
    end
    bus.coeff_busy = 1'b0;
    run_txn("coeff_rel", 2'b10, 16'hBEEF, 16'h7777, 1'b0, 1'b0, 1);
    bus.req_valid = 2'b00;
    tick();

    // Error pulse affects only its own result
    bus.req_sample0 = 16'h0F0F;
    bus.req_valid   = 2'b01;
    run_txn("err_pulse", 2'b01, 16'h0F0F, 16'h1111, 1'b1, 1'b0, 20);
    run_txn("err_clear", 2'b01, 16'h0F0F, 16'h2222, 1'b0, 1'b0, 20);
    bus.req_valid = 2'b00;
    tick();

    // Filter never responds: timeout abort
    bus.req_sample1 = 16'hCAFE;
    bus.req_valid   = 2'b10;
    run_txn("timeout", 2'b10, 16'hCAFE, 16'h0, 1'b0, 1'b1, 20);
    bus.req_valid = 2'b00;
    tick();

    // Reset while the filter is busy
    bus.req_sample0 = 16'h4242;
    bus.req_valid   = 2'b01;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        tick();
        if (bus.req_ack != 2'b00) seen = 1'b1;
      end
      check("rstbusy_ack_seen", 32'(seen), 32'd1);
    end
    bus.req_valid = 2'b00;
    bus.modwait   = 1'b1;
    tick();
    tick();
    n_rst = 1'b0;
    #1;
    check("rstbusy_dr", 32'(bus.data_ready), 32'h0);
    check("rstbusy_ack", 32'(bus.req_ack), 32'h0);
    check("rstbusy_sample", 32'(bus.sample_data), 32'h0);
    check("rstbusy_rsp", 32'(bus.rsp_valid), 32'h0);
    check("rstbusy_active", 32'(bus.active_ch), 32'h0);
    tick();
    bus.modwait = 1'b0;
    n_rst       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rstbusy_no_rsp", 32'(bus.rsp_valid), 32'h0);
    end
    bus.req_sample0 = 16'h1357;
    bus.req_sample1 = 16'h2468;
    bus.req_valid   = 2'b11;
    run_txn("post_rst_tie", 2'b01, 16'h1357, 16'h0999, 1'b0, 1'b0, 20);
    bus.req_valid = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
